opb_register_bank_ppc2simulink: RTL and testbench
=================================================

Name: opb_register_bank_ppc2simulink

Overview:
- Parametrised successor to the single-word PPC-to-Simulink software register: a bank of C_NUM_REGS 32-bit registers behind one OPB slave address window.
- Adds byte-enable writes, readback of every register, and a per-register write-valid strobe.
- Adds an optional self-clearing "pulse" mode per register.
- Sits on the OPB bus in the same clock domain as the user logic; no clock crossing.

Parameters:
- C_BASEADDR, 32'h00000000, byte base address of the window.
- C_HIGHADDR, 32'h000000FF, byte top address of the window (inclusive).
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width (fixed at 32).
- C_NUM_REGS, 4, number of registers, 1..64; register i sits at C_BASEADDR + 4*i.
- C_PULSE_MASK, 64'h0, bit i set means register i self-clears one cycle after a write.
- C_RESET_VALUE, 0, 32-bit reset value applied to every register.

Ports:
- OPB_Clk  in  1  single clock for bus and user side.
- OPB_Rst_n  in  1  asynchronous active-low reset.
- OPB_ABus  in  [0:31]  address.
- OPB_BE  in  [0:3]  byte enables; BE[0] covers OPB_DBus[0:7].
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  transfer request.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data; zero outside the ack cycle.
- Sl_xferAck  out  1  one-cycle transfer acknowledge.
- Sl_errAck  out  1  tied 0.
- Sl_retry  out  1  tied 0.
- Sl_toutSup  out  1  tied 0.
- user_data_out  out  C_NUM_REGS*32  register i on bits [32*i+31:32*i].
- user_data_valid  out  C_NUM_REGS  bit i pulses for one cycle when register i is written.

Behaviour:
- Bit mapping: OPB_DBus[k] maps to register bit 31-k. BE[j] enables register bits 31-8j down to 24-8j.
- Hit: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR. Index = (OPB_ABus - C_BASEADDR) >> 2; the low two address bits are ignored.
- FSM states:
  - IDLE: a hit moves to ACK.
  - ACK: lasts exactly one cycle, then moves to HOLD.
  - HOLD: stays until OPB_select=0, then returns to IDLE. This prevents a double ack on a held select.
- Write (the hit is sampled in IDLE at edge T):
  - Enabled bytes of register[index] update at edge T.
  - Sl_xferAck=1 and user_data_valid[index]=1 during cycle T..T+1 only.
  - Disabled bytes keep their value.
  - An all-zero BE still acks and still pulses valid, with data unchanged.
- Read: during the ACK cycle, Sl_DBus = register[index] in mapped bit order. At all other times Sl_DBus = 0. A read has no side effects.
- Index >= C_NUM_REGS but inside the window: still acked; a write is discarded with no valid pulse; a read returns 0.
- Pulse registers (C_PULSE_MASK[i]=1): return to C_RESET_VALUE at the edge after the write edge, so the written value is visible for exactly one cycle. A readback in the ack cycle returns the written value.
- OPB_select dropping before ACK has no effect, since the ack cycle follows the sampling edge unconditionally. OPB_select dropping during HOLD returns to IDLE.
- Reset (asynchronous, any time, including mid-transfer):
  - FSM goes to IDLE; Sl_xferAck=0, Sl_DBus=0, user_data_valid=0.
  - All registers load C_RESET_VALUE.
  - The in-flight write is lost and is not acked.
- Latency: one cycle from the sampled select to ack. Back-to-back transfers are possible every 3 cycles (IDLE, ACK, HOLD, with select low for at least one cycle).

Test Plan:
- Reset, then read all 4 registers at offsets 0x0, 0x4, 0x8, 0xC -> each returns 0; exactly one ack per transfer; errAck, retry and toutSup stay 0.
- Write 0xDEADBEEF to offset 0x8 with BE=1111 -> user_data_out[95:64]=0xDEADBEEF from the ack cycle; user_data_valid=4'b0100 for one cycle; readback returns 0xDEADBEEF.
- Byte enables: set reg0=0x11223344, then write 0xAABBCCDD with BE=0101 -> reg0=0x11BB33DD.
- Pulse mode with C_PULSE_MASK=1: write 0x00000001 to reg0 -> user_data_out[31:0]=1 for exactly one cycle, then 0.
- Out-of-range in-window access, offset 0x40 with C_NUM_REGS=4: write 0xFFFFFFFF -> ack, no valid pulse, no register changes; read -> 0.
- Select held high for 10 cycles -> exactly one ack. Separately, assert OPB_Rst_n low in the cycle after a write is sampled -> no ack and every register = C_RESET_VALUE.

Source files
------------

// File: rtl/opb_register_bank_ppc2simulink.sv
// Bank of C_NUM_REGS 32-bit software registers on one OPB slave window, with
// byte-enable writes, readback, per-register write strobes and optional pulse mode.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR    = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR    = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter int          C_NUM_REGS    = 4,
  parameter logic [63:0] C_PULSE_MASK  = 64'h0,
  parameter logic [31:0] C_RESET_VALUE = 32'h0
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [C_NUM_REGS*32-1:0]  user_data_out,
  output logic [C_NUM_REGS-1:0]     user_data_valid
);

  localparam int IW = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;

  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

  state_t          state;
  logic [31:0]     regs [C_NUM_REGS];
  logic [31:0]     rd_data;
  logic            xfer_ack;
  logic [C_NUM_REGS-1:0] valid;

  logic [31:0]     addr;
  logic [31:0]     offset;
  logic [31:0]     wdata;
  logic [3:0]      be;
  logic            hit;
  logic            in_range;
  logic [IW-1:0]   idx;
  logic            unused_bits;

  // Big-endian bus bit k lands on register bit 31-k, so a plain MSB-aligned copy
  // does the remap; an address below the base wraps far past the window span.
  assign addr     = 32'(OPB_ABus);
  assign wdata    = 32'(OPB_DBus);
  assign be       = OPB_BE;
  assign offset   = addr - C_BASEADDR;
  assign hit      = OPB_select && (offset <= (C_HIGHADDR - C_BASEADDR));
  assign in_range = (offset[31:2] < 30'(C_NUM_REGS));
  assign idx      = offset[IW+1:2];

  assign unused_bits = ^{OPB_seqAddr, offset[1:0], offset[31:IW+2]};

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state    <= IDLE;
      xfer_ack <= 1'b0;
      rd_data  <= 32'h0;
      valid    <= '0;
      for (int i = 0; i < C_NUM_REGS; i++) regs[i] <= C_RESET_VALUE;
    end else begin
      xfer_ack <= 1'b0;
      rd_data  <= 32'h0;
      valid    <= '0;

      // A strobe still high means the pulse register was written last edge.
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (C_PULSE_MASK[i] && valid[i]) regs[i] <= C_RESET_VALUE;
      end

      case (state)
        IDLE: begin
          if (hit) begin
            state    <= ACK;
            xfer_ack <= 1'b1;
            if (OPB_RNW) begin
              rd_data <= in_range ? regs[idx] : 32'h0;
            end else if (in_range) begin
              valid[idx] <= 1'b1;
              for (int b = 0; b < 4; b++) begin
                if (be[b]) regs[idx][8*b +: 8] <= wdata[8*b +: 8];
              end
            end
          end
        end
        ACK:     state <= HOLD;
        HOLD:    if (!OPB_select) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign Sl_DBus         = rd_data;
  assign Sl_xferAck      = xfer_ack;
  assign Sl_errAck       = 1'b0;
  assign Sl_retry        = 1'b0;
  assign Sl_toutSup      = 1'b0;
  assign user_data_valid = valid;

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = regs[g];
  end

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed bench for the OPB register bank: a plain instance plus one with
// register 0 in pulse mode, both driven from the same bus signals.
module tb_opb_register_bank_ppc2simulink;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [0:31]  abus = '0;
  logic [0:3]   be_s = '0;
  logic [0:31]  dbus = '0;
  logic         rnw_s = 1'b0;
  logic         select = 1'b0;
  logic         seq_addr = 1'b0;

  logic [0:31]  sl_dbus, p_dbus;
  logic         sl_ack, sl_err, sl_retry, sl_tout;
  logic         p_ack, p_err, p_retry, p_tout;
  logic [127:0] out, p_out;
  logic [3:0]   valid, p_valid;

  int errors = 0;
  int checks = 0;
  int ack_count = 0;

  logic         cap_ack;
  logic [31:0]  cap_dbus, cap_dbus_next;
  logic [3:0]   cap_valid, cap_valid_next, cap_pvalid;
  logic [127:0] cap_out, cap_out_next;
  logic [31:0]  cap_pout, cap_pout_next;
  int           cap_acks;
  int           a0;

  always #5 clk = ~clk;

  opb_register_bank_ppc2simulink dut (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be_s),
    .OPB_DBus(dbus), .OPB_RNW(rnw_s), .OPB_select(select), .OPB_seqAddr(seq_addr),
    .Sl_DBus(sl_dbus), .Sl_xferAck(sl_ack), .Sl_errAck(sl_err), .Sl_retry(sl_retry),
    .Sl_toutSup(sl_tout), .user_data_out(out), .user_data_valid(valid)
  );

  opb_register_bank_ppc2simulink #(.C_PULSE_MASK(64'h1)) dut_pulse (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be_s),
    .OPB_DBus(dbus), .OPB_RNW(rnw_s), .OPB_select(select), .OPB_seqAddr(seq_addr),
    .Sl_DBus(p_dbus), .Sl_xferAck(p_ack), .Sl_errAck(p_err), .Sl_retry(p_retry),
    .Sl_toutSup(p_tout), .user_data_out(p_out), .user_data_valid(p_valid)
  );

  always @(negedge clk) if (sl_ack === 1'b1) ack_count++;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transfer: drive, capture the ack cycle, capture the cycle after, settle.
  task automatic applyStimulus(input logic rnw, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] data);
    int start;
    @(posedge clk); #1;
    select = 1'b1; rnw_s = rnw; abus = addr; be_s = be; dbus = data;
    start = ack_count;
    @(posedge clk); #1;
    cap_ack = sl_ack; cap_dbus = sl_dbus; cap_valid = valid; cap_out = out;
    cap_pout = p_out[31:0]; cap_pvalid = p_valid;
    select = 1'b0; rnw_s = 1'b0; dbus = '0; be_s = '0;
    @(posedge clk); #1;
    cap_dbus_next = sl_dbus; cap_valid_next = valid; cap_out_next = out;
    cap_pout_next = p_out[31:0];
    @(posedge clk); #1;
    cap_acks = ack_count - start;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ack", sl_ack, 1'b0);
    checkOutput("reset_dbus", sl_dbus, 32'h0);
    checkOutput("reset_valid", valid, 4'h0);
    checkOutput("reset_out", out, 128'h0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'(4 * i), 4'hF, 32'h0);
      checkOutput($sformatf("rd_reset_reg%0d", i), cap_dbus, 32'h0);
      checkOutput($sformatf("rd_reset_acks%0d", i), cap_acks, 1);
      checkOutput($sformatf("tied_low%0d", i), {sl_err, sl_retry, sl_tout}, 3'b000);
    end

    applyStimulus(1'b0, 32'h8, 4'b1111, 32'hDEADBEEF);
    checkOutput("wr8_ack", cap_ack, 1'b1);
    checkOutput("wr8_out_ackcycle", cap_out[95:64], 32'hDEADBEEF);
    checkOutput("wr8_valid", cap_valid, 4'b0100);
    checkOutput("wr8_valid_next", cap_valid_next, 4'b0000);
    checkOutput("wr8_acks", cap_acks, 1);
    applyStimulus(1'b1, 32'h8, 4'hF, 32'h0);
    checkOutput("rd8", cap_dbus, 32'hDEADBEEF);
    checkOutput("rd8_dbus_after", cap_dbus_next, 32'h0);
    checkOutput("rd8_no_valid", cap_valid, 4'b0000);

    applyStimulus(1'b0, 32'h0, 4'b1111, 32'h11223344);
    checkOutput("wr0_full", cap_out[31:0], 32'h11223344);
    applyStimulus(1'b0, 32'h0, 4'b0101, 32'hAABBCCDD);
    checkOutput("wr0_be0101", cap_out[31:0], 32'h11BB33DD);
    checkOutput("wr0_be_valid", cap_valid, 4'b0001);
    applyStimulus(1'b1, 32'h0, 4'hF, 32'h0);
    checkOutput("rd0_be", cap_dbus, 32'h11BB33DD);
    applyStimulus(1'b0, 32'h0, 4'b0000, 32'hFFFFFFFF);
    checkOutput("wr0_be0000_val", cap_out[31:0], 32'h11BB33DD);
    checkOutput("wr0_be0000_valid", cap_valid, 4'b0001);
    checkOutput("wr0_be0000_acks", cap_acks, 1);

    applyStimulus(1'b1, 32'h0000000B, 4'hF, 32'h0);
    checkOutput("rd_lowbits_ignored", cap_dbus, 32'hDEADBEEF);

    applyStimulus(1'b0, 32'h0, 4'b1111, 32'h00000001);
    checkOutput("pulse_ackcycle", cap_pout, 32'h1);
    checkOutput("pulse_next", cap_pout_next, 32'h0);
    checkOutput("pulse_valid", cap_pvalid, 4'b0001);
    checkOutput("nopulse_hold", cap_out_next[31:0], 32'h1);

    applyStimulus(1'b0, 32'h40, 4'b1111, 32'hFFFFFFFF);
    checkOutput("oor_wr_ack", cap_ack, 1'b1);
    checkOutput("oor_wr_valid", cap_valid, 4'b0000);
    checkOutput("oor_wr_regs", cap_out_next, {32'h0, 32'hDEADBEEF, 32'h0, 32'h1});
    applyStimulus(1'b1, 32'h40, 4'hF, 32'h0);
    checkOutput("oor_rd_data", cap_dbus, 32'h0);
    checkOutput("oor_rd_acks", cap_acks, 1);
    applyStimulus(1'b1, 32'hFF, 4'hF, 32'h0);
    checkOutput("top_of_window_acks", cap_acks, 1);
    applyStimulus(1'b1, 32'h100, 4'hF, 32'h0);
    checkOutput("outside_window_acks", cap_acks, 0);
    checkOutput("outside_window_dbus", cap_dbus, 32'h0);

    @(posedge clk); #1;
    select = 1'b1; rnw_s = 1'b1; abus = 32'h8; a0 = ack_count;
    repeat (10) @(posedge clk);
    #1;
    select = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("held_select_acks", ack_count - a0, 1);
    checkOutput("held_select_dbus", sl_dbus, 32'h0);

    @(posedge clk); #1;
    select = 1'b1; rnw_s = 1'b0; abus = 32'h4; be_s = 4'hF; dbus = 32'h12345678;
    a0 = ack_count;
    @(posedge clk); #2;
    rst_n = 1'b0; select = 1'b0;
    #1;
    checkOutput("rst_mid_ack", sl_ack, 1'b0);
    checkOutput("rst_mid_valid", valid, 4'h0);
    checkOutput("rst_mid_out", out, 128'h0);
    checkOutput("rst_mid_pulse_out", p_out, 128'h0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mid_acks", ack_count - a0, 0);
    checkOutput("rst_after_out", out, 128'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
